// File: rtl/feature_pingpong_ctrl.sv
`default_nettype none

`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

// ============================================================================
// Module      : feature_pingpong_ctrl
// Description : Ping-pong feature bank controller. It fills one bank from the
//               fetch stream while the compute engine reads the other bank.
// Revision    : 1.0 - initial release
// ============================================================================
module feature_pingpong_ctrl #(
    parameter int DATA_BUS_WIDTH = `DATA_BUS_WIDTH,
    parameter int ADDR_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic [ADDR_WIDTH-1:0]     tile_words,
    input  logic                      in_valid,
    input  logic [DATA_BUS_WIDTH-1:0] in_data,
    output logic                      in_ready,
    output logic                      fetcher_to_mem,
    output logic [ADDR_WIDTH-1:0]     wr_feature_addr,
    output logic [DATA_BUS_WIDTH-1:0] wr_feature_data,
    output logic                      wr_feature_sel,
    output logic                      compute_start,
    output logic                      compute_bank,
    input  logic                      compute_done,
    output logic [1:0]                bank_full
);

    localparam logic [ADDR_WIDTH:0] c_cnt_one = (ADDR_WIDTH+1)'(1);

    typedef enum logic [0:0] {
        C_IDLE = 1'b0,
        C_BUSY = 1'b1
    } state_t;

    // Fill-side state
    logic                      r_wr_bank;
    logic [ADDR_WIDTH:0]       r_word_cnt;
    logic [ADDR_WIDTH-1:0]     r_tile_len;
    logic [1:0]                r_bank_full;
    logic                      r_rst_gate;

    // Write port registers
    logic                      r_fetch_strobe;
    logic [ADDR_WIDTH-1:0]     r_wr_addr;
    logic [DATA_BUS_WIDTH-1:0] r_wr_data;
    logic                      r_wr_sel;

    // Compute-side state
    state_t                    r_state;
    logic                      r_rd_bank;
    logic                      r_compute_start;
    logic                      r_compute_bank;

    logic                      w_accept;
    logic [ADDR_WIDTH-1:0]     w_len;
    logic [ADDR_WIDTH:0]       w_len_ext;
    logic                      w_last;
    logic                      w_fill_set;
    logic [1:0]                w_bank_full_nxt;

    state_t                    w_state_nxt;
    logic                      w_start_nxt;
    logic                      w_cbank_nxt;
    logic                      w_rd_bank_nxt;
    logic                      w_done_clr;

    // r_rst_gate holds in_ready low for the first cycle after reset release.
    assign in_ready = r_rst_gate && !r_bank_full[r_wr_bank] && !clear;
    assign w_accept = in_valid && in_ready;

    // The first beat of a tile must use the live tile_words, later beats the latch.
    assign w_len      = (r_word_cnt == '0) ? tile_words : r_tile_len;
    assign w_len_ext  = {(w_len == '0), w_len};
    assign w_last     = (r_word_cnt == (w_len_ext - c_cnt_one));
    assign w_fill_set = w_accept && w_last;

    always_comb begin
        w_state_nxt   = r_state;
        w_start_nxt   = 1'b0;
        w_cbank_nxt   = r_compute_bank;
        w_rd_bank_nxt = r_rd_bank;
        w_done_clr    = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (r_bank_full[r_rd_bank]) begin
                    w_state_nxt = C_BUSY;
                    w_start_nxt = 1'b1;
                    w_cbank_nxt = r_rd_bank;
                end
            end
            C_BUSY: begin
                if (compute_done) begin
                    w_state_nxt   = C_IDLE;
                    w_rd_bank_nxt = ~r_rd_bank;
                    w_done_clr    = 1'b1;
                end
            end
            default: w_state_nxt = C_IDLE;
        endcase
    end

    // Fill and release always target different banks, so both may apply at once.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (w_fill_set) begin
            w_bank_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_done_clr) begin
            w_bank_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= C_IDLE;
            r_rd_bank       <= 1'b0;
            r_compute_start <= 1'b0;
            r_compute_bank  <= 1'b0;
        end else if (clear) begin
            r_state         <= C_IDLE;
            r_rd_bank       <= 1'b0;
            r_compute_start <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_rd_bank       <= w_rd_bank_nxt;
            r_compute_start <= w_start_nxt;
            r_compute_bank  <= w_cbank_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_gate <= 1'b0;
        end else begin
            r_rst_gate <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank   <= 1'b0;
            r_word_cnt  <= '0;
            r_tile_len  <= '0;
            r_bank_full <= 2'b00;
        end else if (clear) begin
            r_wr_bank   <= 1'b0;
            r_word_cnt  <= '0;
            r_bank_full <= 2'b00;
        end else begin
            r_bank_full <= w_bank_full_nxt;
            if (w_accept) begin
                if (r_word_cnt == '0) begin
                    r_tile_len <= tile_words;
                end
                if (w_last) begin
                    r_word_cnt <= '0;
                    r_wr_bank  <= ~r_wr_bank;
                end else begin
                    r_word_cnt <= r_word_cnt + c_cnt_one;
                end
            end
        end
    end

    // Address and data only move on an accepted beat; they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_strobe <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_wr_sel       <= 1'b0;
        end else if (clear) begin
            r_fetch_strobe <= 1'b0;
            r_wr_sel       <= 1'b0;
        end else begin
            r_fetch_strobe <= w_accept;
            if (w_accept) begin
                r_wr_addr <= r_word_cnt[ADDR_WIDTH-1:0];
                r_wr_data <= in_data;
                r_wr_sel  <= r_wr_bank;
            end
        end
    end

    assign fetcher_to_mem  = r_fetch_strobe;
    assign wr_feature_addr = r_wr_addr;
    assign wr_feature_data = r_wr_data;
    assign wr_feature_sel  = r_wr_sel;
    assign compute_start   = r_compute_start;
    assign compute_bank    = r_compute_bank;
    assign bank_full       = r_bank_full;

endmodule

`default_nettype wire

// File: tb/tb_feature_pingpong_ctrl.sv
`default_nettype none

// ============================================================================
// Module      : tb_feature_pingpong_ctrl
// Description : Self-checking bench: write-strobe scoreboard, cycle model and
//               a table of tile scenarios with hand-derived expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_feature_pingpong_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic [AW-1:0] tile_words;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          fetcher_to_mem;
    logic [AW-1:0] wr_feature_addr;
    logic [DW-1:0] wr_feature_data;
    logic          wr_feature_sel;
    logic          compute_start;
    logic          compute_bank;
    logic          compute_done;
    logic [1:0]    bank_full;

    feature_pingpong_ctrl #(
        .DATA_BUS_WIDTH (DW),
        .ADDR_WIDTH     (AW)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .tile_words      (tile_words),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .fetcher_to_mem  (fetcher_to_mem),
        .wr_feature_addr (wr_feature_addr),
        .wr_feature_data (wr_feature_data),
        .wr_feature_sel  (wr_feature_sel),
        .compute_start   (compute_start),
        .compute_bank    (compute_bank),
        .compute_done    (compute_done),
        .bank_full       (bank_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          sel;
    } wr_t;

    typedef struct {
        logic [AW-1:0] tw;
        int            beats;
        logic          pre_done;
        logic [1:0]    bf;
        logic          rdy;
        logic          cbank;
    } row_t;

    wr_t  sb[$];
    row_t rows[5];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic          m_gate;
    logic [1:0]    m_bf;
    logic          m_wb;
    logic          m_rb;
    int            m_wc;
    logic [AW-1:0] m_len;
    logic          m_busy;
    logic          m_start;
    logic          m_cbank;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gate  = 1'b0;
        m_bf    = 2'b00;
        m_wb    = 1'b0;
        m_rb    = 1'b0;
        m_wc    = 0;
        m_len   = '0;
        m_busy  = 1'b0;
        m_start = 1'b0;
        m_cbank = 1'b0;
        sb.delete();
    endtask

    // Called at posedge+1: drive inputs, predict, advance one clock, compare.
    task automatic cycle(input logic v, input logic clr, input logic done);
        logic [DW-1:0] d;
        logic          exp_ready;
        logic          acc;
        logic          exp_strobe;
        logic [1:0]    nbf;
        logic [AW-1:0] len;
        int            lenx;
        wr_t           e;
        d            = $urandom;
        in_valid     = v;
        in_data      = d;
        clear        = clr;
        compute_done = done;
        #1;
        exp_ready = m_gate && !m_bf[m_wb] && !clr;
        chk("in_ready", in_ready, exp_ready);
        acc = v && exp_ready;
        if (clr) begin
            m_wc    = 0;
            m_wb    = 1'b0;
            m_rb    = 1'b0;
            m_bf    = 2'b00;
            m_busy  = 1'b0;
            m_start = 1'b0;
        end else begin
            nbf = m_bf;
            if (acc) begin
                e.addr = AW'(m_wc);
                e.data = d;
                e.sel  = m_wb;
                sb.push_back(e);
                len = (m_wc == 0) ? tile_words : m_len;
                if (m_wc == 0) m_len = tile_words;
                lenx = (len == 0) ? (1 << AW) : int'(len);
                if (m_wc == lenx - 1) begin
                    nbf[m_wb] = 1'b1;
                    m_wb      = !m_wb;
                    m_wc      = 0;
                end else begin
                    m_wc++;
                end
            end
            m_start = 1'b0;
            if (!m_busy) begin
                if (m_bf[m_rb]) begin
                    m_start = 1'b1;
                    m_cbank = m_rb;
                    m_busy  = 1'b1;
                end
            end else if (done) begin
                nbf[m_rb] = 1'b0;
                m_rb      = !m_rb;
                m_busy    = 1'b0;
            end
            m_bf = nbf;
        end
        m_gate = 1'b1;
        @(posedge clk);
        #1;
        exp_strobe = (sb.size() != 0);
        chk("fetcher_to_mem", fetcher_to_mem, exp_strobe);
        if (exp_strobe) begin
            e = sb.pop_front();
            chk("wr_feature_addr", wr_feature_addr, e.addr);
            chk("wr_feature_data", wr_feature_data, e.data);
            chk("wr_feature_sel", wr_feature_sel, e.sel);
        end
        chk("bank_full", bank_full, m_bf);
        chk("compute_start", compute_start, m_start);
        chk("compute_bank", compute_bank, m_cbank);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0] = '{4, 4, 1'b0, 2'b01, 1'b1, 1'b0};
        rows[1] = '{4, 5, 1'b0, 2'b11, 1'b0, 1'b0};
        rows[2] = '{4, 4, 1'b1, 2'b11, 1'b0, 1'b1};
        rows[3] = '{3, 2, 1'b1, 2'b01, 1'b1, 1'b0};
        rows[4] = '{7, 1, 1'b1, 2'b10, 1'b1, 1'b1};

        rst_n        = 1'b0;
        clear        = 1'b0;
        tile_words   = 8'd4;
        in_valid     = 1'b0;
        in_data      = '0;
        compute_done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_strobe", fetcher_to_mem, 1'b0);
        chk("rst_addr", wr_feature_addr, '0);
        chk("rst_data", wr_feature_data, '0);
        chk("rst_bank_full", bank_full, 2'b00);
        chk("rst_start", compute_start, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);

        // Tile scenarios: fill, overflow attempt, releases, mid-tile tile_words change
        for (int i = 0; i < 5; i++) begin
            tile_words = rows[i].tw;
            if (rows[i].pre_done) cycle(1'b0, 1'b0, 1'b1);
            for (int b = 0; b < rows[i].beats; b++) cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
            chk($sformatf("row%0d_bank_full", i), bank_full, rows[i].bf);
            chk($sformatf("row%0d_in_ready", i), in_ready, rows[i].rdy);
            chk($sformatf("row%0d_compute_bank", i), compute_bank, rows[i].cbank);
        end

        // Full-size tile (tile_words=0), tile_words changes mid-tile
        cycle(1'b0, 1'b1, 1'b0);
        tile_words = 8'd0;
        for (int i = 0; i < 256; i++) begin
            if (i == 10) tile_words = 8'd2;
            cycle(1'b1, 1'b0, 1'b0);
            if (i == 254) chk("big_tile_not_full", bank_full, 2'b00);
        end
        chk("big_tile_full", bank_full, 2'b01);
        chk("big_tile_last_addr", wr_feature_addr, 8'd255);

        // Clear on beat 2 while compute_done pulses
        tile_words = 8'd4;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("clr_bank_full", bank_full, 2'b00);
        chk("clr_sel", wr_feature_sel, 1'b0);
        chk("clr_strobe", fetcher_to_mem, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("clr_restart_addr", wr_feature_addr, 8'd0);
        for (int b = 0; b < 3; b++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-tile
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_strobe", fetcher_to_mem, 1'b0);
        chk("arst_addr", wr_feature_addr, '0);
        chk("arst_data", wr_feature_data, '0);
        chk("arst_sel", wr_feature_sel, 1'b0);
        chk("arst_start", compute_start, 1'b0);
        chk("arst_cbank", compute_bank, 1'b0);
        chk("arst_bank_full", bank_full, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("post_rst_bank_full", bank_full, 2'b00);
        for (int b = 0; b < 4; b++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("post_rst_tile_full", bank_full, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/feature_pingpong_ctrl.md
FEATURE_PINGPONG_CTRL -- requirements
Module: feature_pingpong_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_BUS_WIDTH, default `DATA_BUS_WIDTH, meaning width of one feature write word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning feature bank word-address width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 clear  input  1  synchronous flush of all tile/bank state.
REQ-007 tile_words  input  ADDR_WIDTH  words per tile; 0 means 2^ADDR_WIDTH.
REQ-008 in_valid  input  1  fetch stream word valid.
REQ-009 in_data  input  DATA_BUS_WIDTH  fetch stream word.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 fetcher_to_mem  output  1  bank write strobe to feature_load.
REQ-012 wr_feature_addr  output  ADDR_WIDTH  bank write word address.
REQ-013 wr_feature_data  output  DATA_BUS_WIDTH  bank write data.
REQ-014 wr_feature_sel  output  1  target bank (0/1) for feature_load.
REQ-015 compute_start  output  1  one-cycle pulse: tile in compute_bank ready.
REQ-016 compute_bank  output  1  bank the compute engine shall read.
REQ-017 compute_done  input  1  one-cycle pulse: compute engine released compute_bank.
REQ-018 bank_full  output  2  per-bank tile-complete flags.

Function
REQ-019 Internal state SHALL be: wr_bank (1b), word_cnt (ADDR_WIDTH+1 b), tile_len latch, bank_full[1:0], rd_bank (1b), compute FSM {C_IDLE, C_BUSY}.
REQ-020 in_ready SHALL be combinational: !bank_full[wr_bank] && !clear.
REQ-021 A beat SHALL be accepted when in_valid && in_ready.
REQ-022 On an accepted beat in cycle N, cycle N+1 SHALL show fetcher_to_mem=1, wr_feature_addr=word_cnt (at N), wr_feature_data=in_data (at N), wr_feature_sel=wr_bank (at N); fetcher_to_mem=0 in any cycle following no accepted beat.
REQ-023 wr_feature_addr and wr_feature_data SHALL hold their last values while fetcher_to_mem=0.
REQ-024 tile_len SHALL latch tile_words on the first accepted beat of a tile (word_cnt=0); tile_words changes mid-tile SHALL be ignored.
REQ-025 word_cnt SHALL increment per accepted beat; on the beat where word_cnt = tile_len-1 (tile_len 0 read as 2^ADDR_WIDTH), the next cycle SHALL set bank_full[wr_bank]=1, toggle wr_bank, and reset word_cnt to 0.
REQ-026 bank_full set SHALL be visible in the same cycle as the final write strobe; in_ready SHALL drop the following cycle only if the new wr_bank is also full.
REQ-027 In C_IDLE with bank_full[rd_bank]=1, the next cycle SHALL assert compute_start for exactly one cycle, compute_bank=rd_bank, state C_BUSY.
REQ-028 In C_BUSY, compute_done SHALL clear bank_full[rd_bank], toggle rd_bank, return to C_IDLE next cycle; compute_start SHALL NOT reassert earlier than the cycle after that.
REQ-029 compute_done in C_IDLE SHALL be ignored.
REQ-030 compute_bank SHALL hold its value between starts.
REQ-031 Fill-set and done-clear in the same cycle SHALL both take effect; they always target different banks.
REQ-032 clear=1 SHALL, next cycle, zero word_cnt, wr_bank, rd_bank, bank_full, fetcher_to_mem, compute_start, and force C_IDLE; clear SHALL override simultaneous beats and compute_done.
REQ-033 No beat SHALL ever be written to a bank whose bank_full is 1.

Reset
REQ-034 rst_n=0 SHALL asynchronously force: in_ready=0 via internal gating released one cycle after rst_n rises, fetcher_to_mem=0, wr_feature_addr=0, wr_feature_data=0, wr_feature_sel=0, compute_start=0, compute_bank=0, bank_full=2'b00, word_cnt=0, rd_bank=0, state C_IDLE.
REQ-035 Reset asserted mid-tile SHALL discard the partial tile; no write strobe after deassertion without a new accepted beat.

Verification
REQ-036 tile_words=4, 4 back-to-back beats D0..D3 -> strobes addr 0..3 sel=0 cycles 1..4; bank_full=01 at cycle 4; compute_start, bank 0, at cycle 5.
REQ-037 Two 4-word tiles, no compute_done -> second tile to sel=1, bank_full=11, in_ready=0, extra in_valid produces no strobe.
REQ-038 Both banks full, compute_done pulse -> bank_full=10, in_ready=1 next cycle, next tile writes sel=0; next compute_start, bank 1, one cycle after C_IDLE.
REQ-039 tile_words=0, 256 beats -> addr 0..255, bank_full set only after beat 256; tile_words changed to 2 at beat 10 has no effect.
REQ-040 clear asserted on beat 2 of a tile while compute_done pulses -> all flags 0, wr_feature_sel=0, no strobe next cycle, next tile restarts at addr 0.
REQ-041 rst_n pulsed low mid-tile asynchronously -> all outputs 0 before next clk edge; compute_done after reset produces no state change.
